// File: rtl/frame_renderer_pkg.sv
// Shared types for the frame renderer: FSM states, sprite descriptor and palette constants.
package frame_renderer_pkg;

  localparam int unsigned CoordW = 12;
  localparam int unsigned DimW   = 7;
  localparam int unsigned RomAw  = 16;

  localparam logic [2:0] TRANSPARENT = 3'd0;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitLow = 3'd1,
    StClear   = 3'd2,
    StFetch   = 3'd3,
    StDraw    = 3'd4,
    StDone    = 3'd5
  } state_e;

  typedef struct packed {
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
    logic [DimW-1:0]   w;
    logic [DimW-1:0]   h;
    logic [RomAw-1:0]  base;
    logic              valid;
  } spr_desc_t;

endpackage

// File: rtl/sprite_raster_walker.sv
// Walks one sprite row-major, issuing ROM addresses and pairing rom_data with its clipped
// screen coordinate one cycle later.
module sprite_raster_walker
  import frame_renderer_pkg::*;
#(
  parameter int unsigned FRAME_W = 1280,
  parameter int unsigned FRAME_H = 300
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              flush_i,
  input  spr_desc_t         desc_i,
  input  logic [2:0]        rom_data_i,
  output logic              desc_ok_o,
  output logic [RomAw-1:0]  rom_addr_o,
  output logic              done_o,
  output logic              pix_valid_o,
  output logic [CoordW-1:0] pix_x_o,
  output logic [CoordW-1:0] pix_y_o,
  output logic [2:0]        pix_pal_o
);

  logic [CoordW-1:0] x_q, x_d;
  logic [DimW-1:0]   w_q, w_d, h_q, h_d;
  logic [DimW-1:0]   px_q, px_d, py_q, py_d;
  logic [RomAw-1:0]  addr_q, addr_d;
  // One extra bit so sprites hanging past the coordinate range clip instead of wrapping.
  logic [CoordW:0]   sx0_q, sx0_d, sy0_q, sy0_d, sx1_q, sx1_d, sy1_q, sy1_d;
  logic              v0_q, v0_d, v1_q, v1_d;

  assign desc_ok_o = desc_i.valid && (desc_i.w != '0) && (desc_i.h != '0);

  always_comb begin
    x_d    = x_q;
    w_d    = w_q;
    h_d    = h_q;
    px_d   = px_q;
    py_d   = py_q;
    addr_d = addr_q;
    sx0_d  = sx0_q;
    sy0_d  = sy0_q;
    v0_d   = v0_q;
    sx1_d  = sx0_q;
    sy1_d  = sy0_q;
    v1_d   = v0_q;
    if (flush_i) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else if (start_i) begin
      x_d    = desc_i.x;
      w_d    = desc_i.w;
      h_d    = desc_i.h;
      px_d   = '0;
      py_d   = '0;
      addr_d = desc_i.base;
      sx0_d  = {1'b0, desc_i.x};
      sy0_d  = {1'b0, desc_i.y};
      v0_d   = 1'b1;
    end else if (v0_q) begin
      if (px_q == w_q - DimW'(1)) begin
        px_d  = '0;
        sx0_d = {1'b0, x_q};
        if (py_q == h_q - DimW'(1)) begin
          v0_d = 1'b0;
        end else begin
          py_d   = py_q + DimW'(1);
          sy0_d  = sy0_q + (CoordW+1)'(1);
          addr_d = addr_q + RomAw'(1);
        end
      end else begin
        px_d   = px_q + DimW'(1);
        sx0_d  = sx0_q + (CoordW+1)'(1);
        addr_d = addr_q + RomAw'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= '0;
      w_q    <= '0;
      h_q    <= '0;
      px_q   <= '0;
      py_q   <= '0;
      addr_q <= '0;
      sx0_q  <= '0;
      sy0_q  <= '0;
      sx1_q  <= '0;
      sy1_q  <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      w_q    <= w_d;
      h_q    <= h_d;
      px_q   <= px_d;
      py_q   <= py_d;
      addr_q <= addr_d;
      sx0_q  <= sx0_d;
      sy0_q  <= sy0_d;
      sx1_q  <= sx1_d;
      sy1_q  <= sy1_d;
      v0_q   <= v0_d;
      v1_q   <= v1_d;
    end
  end

  assign rom_addr_o  = addr_q;
  assign done_o      = !v0_q && !v1_q;
  assign pix_valid_o = v1_q && (rom_data_i != TRANSPARENT) &&
                       (sx1_q < (CoordW+1)'(FRAME_W)) && (sy1_q < (CoordW+1)'(FRAME_H));
  assign pix_x_o     = sx1_q[CoordW-1:0];
  assign pix_y_o     = sy1_q[CoordW-1:0];
  assign pix_pal_o   = rom_data_i;

endmodule

// File: rtl/frame_renderer.sv
// Per-frame renderer: clears the frame buffer, then rasterises the sprite table into the
// frame-buffer pixel-write interface, one pixel per cycle.
module frame_renderer
  import frame_renderer_pkg::*;
#(
  parameter int unsigned COOR_WIDTH     = CoordW,
  parameter int unsigned FRAME_W        = 1280,
  parameter int unsigned FRAME_H        = 300,
  parameter int unsigned CLEAR_PALETTE  = 7,
  parameter int unsigned MAX_SPRITES    = 32,
  parameter int unsigned SPR_IDX_WIDTH  = 5,
  parameter int unsigned SPR_DIM_WIDTH  = DimW,
  parameter int unsigned ROM_ADDR_WIDTH = RomAw
) (
  input  logic                      clk_33m,
  input  logic                      rst_n,
  input  logic                      rst_screen_33m,
  output logic [SPR_IDX_WIDTH-1:0]  spr_index,
  input  logic                      spr_valid,
  input  logic [COOR_WIDTH-1:0]     spr_x,
  input  logic [COOR_WIDTH-1:0]     spr_y,
  input  logic [SPR_DIM_WIDTH-1:0]  spr_w,
  input  logic [SPR_DIM_WIDTH-1:0]  spr_h,
  input  logic [ROM_ADDR_WIDTH-1:0] spr_base,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [2:0]                rom_data,
  output logic [COOR_WIDTH-1:0]     write_x,
  output logic [COOR_WIDTH-1:0]     write_y,
  output logic [2:0]                write_palette,
  output logic                      busy,
  output logic                      frame_overrun
);

  localparam logic [COOR_WIDTH-1:0]    LastX   = COOR_WIDTH'(FRAME_W - 1);
  localparam logic [COOR_WIDTH-1:0]    LastY   = COOR_WIDTH'(FRAME_H - 1);
  localparam logic [SPR_IDX_WIDTH-1:0] LastIdx = SPR_IDX_WIDTH'(MAX_SPRITES - 1);
  localparam logic [2:0]               ClrPal  = 3'(CLEAR_PALETTE);

  state_e                   state_q, state_d;
  logic                     scr_q;
  logic [COOR_WIDTH-1:0]    cx_q, cx_d, cy_q, cy_d;
  logic [SPR_IDX_WIDTH-1:0] idx_q, idx_d;
  logic                     busy_q, busy_d, ovr_q, ovr_d;
  logic [COOR_WIDTH-1:0]    wx_q, wx_d, wy_q, wy_d;
  logic [2:0]               wpal_q, wpal_d;

  logic                     frame_start;
  logic                     walk_start, walk_flush, walk_ok, walk_done;
  logic                     pix_valid;
  logic [COOR_WIDTH-1:0]    pix_x, pix_y;
  logic [2:0]               pix_pal;
  spr_desc_t                desc;

  assign frame_start = rst_screen_33m && !scr_q;
  assign desc = '{x: spr_x, y: spr_y, w: spr_w, h: spr_h, base: spr_base, valid: spr_valid};

  sprite_raster_walker #(
    .FRAME_W(FRAME_W),
    .FRAME_H(FRAME_H)
  ) u_walker (
    .clk_i      (clk_33m),
    .rst_ni     (rst_n),
    .start_i    (walk_start),
    .flush_i    (walk_flush),
    .desc_i     (desc),
    .rom_data_i (rom_data),
    .desc_ok_o  (walk_ok),
    .rom_addr_o (rom_addr),
    .done_o     (walk_done),
    .pix_valid_o(pix_valid),
    .pix_x_o    (pix_x),
    .pix_y_o    (pix_y),
    .pix_pal_o  (pix_pal)
  );

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    ovr_d      = 1'b0;
    wx_d       = wx_q;
    wy_d       = wy_q;
    wpal_d     = TRANSPARENT;
    walk_start = 1'b0;
    walk_flush = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        if (frame_start) begin
          state_d = StWaitLow;
          busy_d  = 1'b1;
        end
      end
      StWaitLow: begin
        // Emit pixel (0,0) on the fall so the first write lands the cycle after it.
        if (!rst_screen_33m) begin
          wx_d    = '0;
          wy_d    = '0;
          wpal_d  = ClrPal;
          cx_d    = COOR_WIDTH'(1);
          cy_d    = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        wx_d   = cx_q;
        wy_d   = cy_q;
        wpal_d = ClrPal;
        if (cx_q == LastX) begin
          cx_d = '0;
          if (cy_q == LastY) begin
            idx_d   = '0;
            state_d = StFetch;
          end else begin
            cy_d = cy_q + COOR_WIDTH'(1);
          end
        end else begin
          cx_d = cx_q + COOR_WIDTH'(1);
        end
      end
      StFetch: begin
        if (walk_ok) begin
          walk_start = 1'b1;
          state_d    = StDraw;
        end else if (idx_q == LastIdx) begin
          busy_d  = 1'b0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + SPR_IDX_WIDTH'(1);
        end
      end
      StDraw: begin
        if (pix_valid) begin
          wx_d   = pix_x;
          wy_d   = pix_y;
          wpal_d = pix_pal;
        end
        if (walk_done) begin
          if (idx_q == LastIdx) begin
            busy_d  = 1'b0;
            state_d = StDone;
          end else begin
            idx_d   = idx_q + SPR_IDX_WIDTH'(1);
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A new frame before the current one finished aborts everything in flight.
    if (frame_start && (state_q != StIdle) && (state_q != StDone)) begin
      ovr_d      = 1'b1;
      walk_flush = 1'b1;
      walk_start = 1'b0;
      wpal_d     = TRANSPARENT;
      busy_d     = 1'b1;
      state_d    = StWaitLow;
    end
  end

  always_ff @(posedge clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      scr_q   <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      wpal_q  <= TRANSPARENT;
    end else begin
      state_q <= state_d;
      scr_q   <= rst_screen_33m;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wpal_q  <= wpal_d;
    end
  end

  assign spr_index     = idx_q;
  assign write_x       = wx_q;
  assign write_y       = wy_q;
  assign write_palette = wpal_q;
  assign busy          = busy_q;
  assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Directed bench for frame_renderer on a 16x8 frame with a behavioural sprite table and ROM.
module tb_frame_renderer;

  localparam int FW = 16;
  localparam int FH = 8;

  logic        clk_33m = 1'b0;
  logic        rst_n;
  logic        rst_screen_33m;
  logic [4:0]  spr_index;
  logic        spr_valid;
  logic [11:0] spr_x, spr_y;
  logic [6:0]  spr_w, spr_h;
  logic [15:0] spr_base;
  logic [15:0] rom_addr;
  logic [2:0]  rom_data = 3'd0;
  logic [11:0] write_x, write_y;
  logic [2:0]  write_palette;
  logic        busy, frame_overrun;

  logic        tv [32];
  logic [11:0] tx [32];
  logic [11:0] ty [32];
  logic [6:0]  tw [32];
  logic [6:0]  th [32];
  logic [15:0] tb [32];
  logic [2:0]  rom_mem [65536];

  typedef struct {int x; int y; int pal; int cyc;} wr_t;
  wr_t wlog[$];
  int  cyc = 0;
  int  addr100_cyc = -1;
  int  seen200 = 0;
  int  ovr_cnt = 0;
  int  errors = 0;
  int  checks = 0;

  frame_renderer #(
    .FRAME_W(FW),
    .FRAME_H(FH)
  ) dut (
    .clk_33m       (clk_33m),
    .rst_n         (rst_n),
    .rst_screen_33m(rst_screen_33m),
    .spr_index     (spr_index),
    .spr_valid     (spr_valid),
    .spr_x         (spr_x),
    .spr_y         (spr_y),
    .spr_w         (spr_w),
    .spr_h         (spr_h),
    .spr_base      (spr_base),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .write_x       (write_x),
    .write_y       (write_y),
    .write_palette (write_palette),
    .busy          (busy),
    .frame_overrun (frame_overrun)
  );

  always #5 clk_33m = ~clk_33m;

  assign spr_valid = tv[spr_index];
  assign spr_x     = tx[spr_index];
  assign spr_y     = ty[spr_index];
  assign spr_w     = tw[spr_index];
  assign spr_h     = th[spr_index];
  assign spr_base  = tb[spr_index];

  always @(posedge clk_33m) begin
    rom_data <= rom_mem[rom_addr];
    cyc      <= cyc + 1;
  end

  always @(negedge clk_33m) begin
    if (rst_n && write_palette != 3'd0)
      wlog.push_back('{int'(write_x), int'(write_y), int'(write_palette), cyc});
    if (rom_addr == 16'd100 && addr100_cyc < 0) addr100_cyc <= cyc;
    if (rom_addr == 16'd200) seen200 <= 1;
    if (frame_overrun) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_33m);
    #1;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 32; i++) begin
      tv[i] = 1'b0; tx[i] = '0; ty[i] = '0; tw[i] = '0; th[i] = '0; tb[i] = '0;
    end
  endtask

  task automatic set_spr(input int i, input int x, input int y, input int w, input int h,
                         input int base);
    tv[i] = 1'b1; tx[i] = 12'(x); ty[i] = 12'(y); tw[i] = 7'(w); th[i] = 7'(h); tb[i] = 16'(base);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: busy still %0b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic run_frame(input string name);
    wlog.delete();
    addr100_cyc = -1;
    seen200 = 0;
    rst_screen_33m = 1'b1;
    repeat (5) tick();
    rst_screen_33m = 1'b0;
    tick();
    wait_idle(name);
  endtask

  task automatic test_reset();
    checks++;
    if (write_x !== 12'd0 || write_y !== 12'd0 || write_palette !== 3'd0) begin
      errors++;
      $display("FAIL reset_write: got (%0d,%0d,%0d), required (0,0,0)",
               write_x, write_y, write_palette);
    end
    checks++;
    if (spr_index !== 5'd0 || rom_addr !== 16'd0) begin
      errors++;
      $display("FAIL reset_index: spr_index=%0d rom_addr=%0d, required 0 0", spr_index, rom_addr);
    end
    checks++;
    if (busy !== 1'b0 || frame_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%0b overrun=%0b, required 0 0", busy, frame_overrun);
    end
  endtask

  task automatic test_clear();
    int n;
    int bad;
    clear_table();
    ovr_cnt = 0;
    rst_screen_33m = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || write_palette !== 3'd0) begin
      errors++;
      $display("FAIL clear_start: busy=%0b pal=%0d, required 1 0", busy, write_palette);
    end
    repeat (4) tick();
    rst_screen_33m = 1'b0;
    tick();
    checks++;
    if (write_x !== 12'd0 || write_y !== 12'd0 || write_palette !== 3'd7) begin
      errors++;
      $display("FAIL clear_first: got (%0d,%0d,%0d), required (0,0,7)",
               write_x, write_y, write_palette);
    end
    n = 1;
    bad = 0;
    while (n < 1000) begin
      tick();
      if (write_palette !== 3'd7) break;
      if (int'(write_x) != n % FW || int'(write_y) != n / FW) bad++;
      if (n == FW * FH - 1 && (write_x !== 12'd15 || write_y !== 12'd7)) begin
        errors++;
        $display("FAIL clear_last: got (%0d,%0d), required (15,7)", write_x, write_y);
      end
      n++;
    end
    checks++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_order: %0d out-of-order writes, required 0", bad);
    end
    checks++;
    if (n != FW * FH) begin
      errors++;
      $display("FAIL clear_count: got %0d writes, required %0d", n, FW * FH);
    end
    // Now one cycle past the last write; table walk of 32 empty entries follows.
    repeat (30) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_busy_hold: busy=%0b, required 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_busy_fall: busy=%0b, required 0", busy);
    end
    checks++;
    if (rom_addr !== 16'd0 || ovr_cnt != 0) begin
      errors++;
      $display("FAIL clear_quiet: rom_addr=%0d overruns=%0d, required 0 0", rom_addr, ovr_cnt);
    end
  endtask

  task automatic test_sprite_basic();
    clear_table();
    set_spr(0, 3, 2, 2, 2, 100);
    set_spr(1, 8, 1, 0, 3, 200);
    rom_mem[100] = 3'd1; rom_mem[101] = 3'd0; rom_mem[102] = 3'd3; rom_mem[103] = 3'd4;
    for (int i = 200; i < 210; i++) rom_mem[i] = 3'd5;
    run_frame("basic_done");
    checks++;
    if (wlog.size() != FW * FH + 3) begin
      errors++;
      $display("FAIL basic_count: got %0d writes, required %0d", wlog.size(), FW * FH + 3);
    end else begin
      checks++;
      if (wlog[128].x != 3 || wlog[128].y != 2 || wlog[128].pal != 1) begin
        errors++;
        $display("FAIL basic_px0: got (%0d,%0d,%0d), required (3,2,1)",
                 wlog[128].x, wlog[128].y, wlog[128].pal);
      end
      checks++;
      if (wlog[129].x != 3 || wlog[129].y != 3 || wlog[129].pal != 3) begin
        errors++;
        $display("FAIL basic_px2: got (%0d,%0d,%0d), required (3,3,3)",
                 wlog[129].x, wlog[129].y, wlog[129].pal);
      end
      checks++;
      if (wlog[130].x != 4 || wlog[130].y != 3 || wlog[130].pal != 4) begin
        errors++;
        $display("FAIL basic_px3: got (%0d,%0d,%0d), required (4,3,4)",
                 wlog[130].x, wlog[130].y, wlog[130].pal);
      end
      checks++;
      if (wlog[128].cyc - addr100_cyc != 2) begin
        errors++;
        $display("FAIL basic_latency: got %0d cycles, required 2", wlog[128].cyc - addr100_cyc);
      end
    end
    checks++;
    if (seen200 != 0) begin
      errors++;
      $display("FAIL basic_skip_w0: rom read of skipped sprite seen=%0d, required 0", seen200);
    end
  endtask

  task automatic test_clip();
    clear_table();
    set_spr(0, 15, 7, 3, 2, 300);
    set_spr(1, 4094, 0, 4, 1, 300);
    for (int i = 300; i < 310; i++) rom_mem[i] = 3'd5;
    run_frame("clip_done");
    checks++;
    if (wlog.size() != FW * FH + 1) begin
      errors++;
      $display("FAIL clip_count: got %0d writes, required %0d", wlog.size(), FW * FH + 1);
    end else begin
      checks++;
      if (wlog[128].x != 15 || wlog[128].y != 7 || wlog[128].pal != 5) begin
        errors++;
        $display("FAIL clip_corner: got (%0d,%0d,%0d), required (15,7,5)",
                 wlog[128].x, wlog[128].y, wlog[128].pal);
      end
    end
  endtask

  task automatic test_overlap();
    int last_pal;
    clear_table();
    set_spr(0, 5, 5, 1, 1, 400);
    set_spr(1, 4, 4, 2, 2, 410);
    rom_mem[400] = 3'd2;
    for (int i = 410; i < 414; i++) rom_mem[i] = 3'd6;
    run_frame("overlap_done");
    last_pal = -1;
    foreach (wlog[i]) if (wlog[i].x == 5 && wlog[i].y == 5) last_pal = wlog[i].pal;
    checks++;
    if (wlog.size() != FW * FH + 5) begin
      errors++;
      $display("FAIL overlap_count: got %0d writes, required %0d", wlog.size(), FW * FH + 5);
    end else begin
      checks++;
      if (wlog[128].pal != 2) begin
        errors++;
        $display("FAIL overlap_first: got palette %0d, required 2", wlog[128].pal);
      end
    end
    checks++;
    if (last_pal != 6) begin
      errors++;
      $display("FAIL overlap_last: got palette %0d at (5,5), required 6", last_pal);
    end
  endtask

  task automatic test_overrun();
    int n;
    int bad;
    clear_table();
    ovr_cnt = 0;
    rst_screen_33m = 1'b1;
    repeat (5) tick();
    rst_screen_33m = 1'b0;
    n = 0;
    while (n < 300 && !(write_y == 12'd4 && write_x == 12'd0 && write_palette == 3'd7)) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL overrun_reach: row 4 not reached in %0d cycles, required < 300", n);
    end
    rst_screen_33m = 1'b1;
    tick();
    checks++;
    if (frame_overrun !== 1'b1 || write_palette !== 3'd0) begin
      errors++;
      $display("FAIL overrun_pulse: overrun=%0b pal=%0d, required 1 0",
               frame_overrun, write_palette);
    end
    bad = 0;
    repeat (4) begin
      tick();
      if (frame_overrun !== 1'b0 || write_palette !== 3'd0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL overrun_hold: %0d bad cycles while swap high, required 0", bad);
    end
    rst_screen_33m = 1'b0;
    tick();
    checks++;
    if (write_x !== 12'd0 || write_y !== 12'd0 || write_palette !== 3'd7) begin
      errors++;
      $display("FAIL overrun_restart: got (%0d,%0d,%0d), required (0,0,7)",
               write_x, write_y, write_palette);
    end
    wait_idle("overrun_done");
    checks++;
    if (ovr_cnt != 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d pulses, required 1", ovr_cnt);
    end
  endtask

  task automatic test_async_reset();
    int n;
    int bad;
    clear_table();
    set_spr(0, 0, 0, 4, 4, 500);
    for (int i = 500; i < 516; i++) rom_mem[i] = 3'd3;
    rst_screen_33m = 1'b1;
    repeat (5) tick();
    rst_screen_33m = 1'b0;
    n = 0;
    while (n < 400 && rom_addr != 16'd503) begin
      tick();
      n++;
    end
    checks++;
    if (write_palette !== 3'd3) begin
      errors++;
      $display("FAIL areset_mid_draw: pal=%0d at rom_addr=%0d, required 3", write_palette, rom_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (write_x !== 12'd0 || write_y !== 12'd0 || write_palette !== 3'd0 || busy !== 1'b0 ||
        rom_addr !== 16'd0 || spr_index !== 5'd0 || frame_overrun !== 1'b0) begin
      errors++;
      $display("FAIL areset_zero: x=%0d y=%0d pal=%0d busy=%0b addr=%0d idx=%0d, required all 0",
               write_x, write_y, write_palette, busy, rom_addr, spr_index);
    end
    tick();
    #2 rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (write_palette !== 3'd0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL areset_quiet: %0d cycles with activity after release, required 0", bad);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rst_screen_33m = 1'b0;
    clear_table();
    for (int i = 0; i < 65536; i++) rom_mem[i] = 3'd0;
    tick();
    tick();
    test_reset();
    #2 rst_n = 1'b1;
    tick();
    tick();
    test_clear();
    tick();
    test_sprite_basic();
    tick();
    test_clip();
    tick();
    test_overlap();
    tick();
    test_overrun();
    tick();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
